// File: rtl/xrst_evidence_pkg.sv
// Shared types and packet layout for the XRST evidence builder.
// The CRC constants are consumed only when XRST_EVIDENCE_CRC_EN is defined.
package xrst_evidence_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_BUILD   = 3'd2,
      ST_SEND    = 3'd3,
      ST_WAIT    = 3'd4
   } state_t;

   typedef struct packed {
      logic [31:0]  sla_id;
      logic [31:0]  reliability;
      logic [31:0]  penalty;
      logic [31:0]  credit;
      logic [15:0]  boundary;
      logic [255:0] proof;
   } hdr_t;

   localparam int PKT_W      = 4096;
   localparam int OFF_SLA    = 0;
   localparam int OFF_TS     = 32;
   localparam int OFF_REL    = 64;
   localparam int OFF_PEN    = 96;
   localparam int OFF_CRED   = 128;
   localparam int OFF_BND    = 160;
   localparam int OFF_CHAIN  = 176;
   localparam int OFF_PROOF  = 432;
   localparam int OFF_CNT    = 688;
   localparam int BODY_W     = 704;
   localparam int OFF_CRC    = 4064;
   localparam int CRC_CHUNKS = 11;

   localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;
   localparam logic [7:0]  CORE_IDLE_STATE = 8'd0;

   // Event count field saturates at 16 bits.
   function automatic logic [15:0] sat16(input logic [31:0] c);
      return (c > 32'h0000FFFF) ? 16'hFFFF : c[15:0];
   endfunction

endpackage

// File: rtl/xrst_crc32_step.sv
// Combinational CRC-32 update over one 64-bit chunk, MSB first, non-reflected.
// Only present when XRST_EVIDENCE_CRC_EN is defined.
`ifdef XRST_EVIDENCE_CRC_EN
module xrst_crc32_step
   import xrst_evidence_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [63:0] data,
   output logic [31:0] crc_out
);

   always_comb begin
      logic [31:0] c;
      logic        fb;
      c = crc_in;
      for (int b = 63; b >= 0; b--) begin
         fb = c[31] ^ data[b];
         c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
      end
      crc_out = c;
   end

endmodule
`endif

// File: rtl/xrst_evidence_builder.sv
// XRST evidence producer: header capture, causal chain fold, packet build, core handshake.
// Define XRST_EVIDENCE_CRC_EN to append a CRC-32 of the packet body at [4095:4064].
module xrst_evidence_builder
   import xrst_evidence_pkg::*;
#(
   parameter int MAX_EVENTS     = 1024,
   parameter int SETTLE_TIMEOUT = 4096
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hdr_valid,
   input  logic [31:0]   hdr_sla_id,
   input  logic [31:0]   hdr_reliability,
   input  logic [31:0]   hdr_penalty,
   input  logic [31:0]   hdr_credit,
   input  logic [15:0]   hdr_boundary,
   input  logic [255:0]  hdr_proof,
   input  logic          ev_valid,
   input  logic [63:0]   ev_data,
   input  logic          ev_last,
   output logic          ev_ready,
   input  logic          core_ready_in,
   input  logic [7:0]    core_state_in,
   input  logic          settle_done_in,
   output logic [4095:0] evidence_packet,
   output logic          packet_valid,
   output logic          builder_busy,
   output logic [2:0]    builder_state,
   output logic [31:0]   packets_sent,
   output logic [31:0]   timeout_count,
   output logic          overflow
);

   state_t        state, state_nxt;
   hdr_t          hdr;
   logic [255:0]  chain;
   logic [31:0]   ev_cnt;
   logic [31:0]   ts_cnt;
   logic [31:0]   ts_lat;
   logic [31:0]   wait_cnt;
   logic [BODY_W-1:0] body;
   logic          accept;
   logic          settle_to;
   logic          build_last;

   assign accept    = packet_valid && core_ready_in && (core_state_in == CORE_IDLE_STATE);
   assign settle_to = (wait_cnt == 32'(SETTLE_TIMEOUT - 1));
   assign builder_busy  = (state != ST_IDLE);
   assign builder_state = state;

   always_comb begin
      body = '0;
      body[OFF_SLA   +: 32]  = hdr.sla_id;
      body[OFF_TS    +: 32]  = ts_lat;
      body[OFF_REL   +: 32]  = hdr.reliability;
      body[OFF_PEN   +: 32]  = hdr.penalty;
      body[OFF_CRED  +: 32]  = hdr.credit;
      body[OFF_BND   +: 16]  = hdr.boundary;
      body[OFF_CHAIN +: 256] = chain;
      body[OFF_PROOF +: 256] = hdr.proof;
      body[OFF_CNT   +: 16]  = sat16(ev_cnt);
   end

`ifdef XRST_EVIDENCE_CRC_EN
   logic [3:0]  build_cnt;
   logic [31:0] crc_acc;
   logic [31:0] crc_seed;
   logic [31:0] crc_nxt;
   logic [CRC_CHUNKS-1:0][63:0] chunks;

   assign chunks     = body;
   assign crc_seed   = (build_cnt == 4'd0) ? CRC_INIT : crc_acc;
   assign build_last = (build_cnt == 4'(CRC_CHUNKS - 1));

   xrst_crc32_step u_crc (
      .crc_in  (crc_seed),
      .data    (chunks[build_cnt]),
      .crc_out (crc_nxt)
   );
`else
   assign build_last = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      ev_ready     = 1'b0;
      packet_valid = 1'b0;
      case (state)
         ST_IDLE:    if (hdr_valid) state_nxt = ST_COLLECT;
         ST_COLLECT: begin
            ev_ready = 1'b1;
            if (ev_valid && ev_last) state_nxt = ST_BUILD;
         end
         ST_BUILD:   if (build_last) state_nxt = ST_SEND;
         ST_SEND: begin
            packet_valid = 1'b1;
            if (core_ready_in && (core_state_in == CORE_IDLE_STATE)) state_nxt = ST_WAIT;
         end
         ST_WAIT:    if (settle_done_in || settle_to) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hdr             <= '0;
         chain           <= '0;
         ev_cnt          <= '0;
         ts_cnt          <= '0;
         ts_lat          <= '0;
         wait_cnt        <= '0;
         evidence_packet <= '0;
         packets_sent    <= '0;
         timeout_count   <= '0;
         overflow        <= 1'b0;
`ifdef XRST_EVIDENCE_CRC_EN
         build_cnt       <= '0;
         crc_acc         <= '0;
`endif
      end else begin
         ts_cnt <= ts_cnt + 32'd1;
         case (state)
            ST_IDLE: begin
               if (hdr_valid) begin
                  hdr.sla_id      <= hdr_sla_id;
                  hdr.reliability <= hdr_reliability;
                  hdr.penalty     <= hdr_penalty;
                  hdr.credit      <= hdr_credit;
                  hdr.boundary    <= hdr_boundary;
                  hdr.proof       <= hdr_proof;
                  chain           <= '0;
                  ev_cnt          <= '0;
               end
            end
            ST_COLLECT: begin
               if (ev_valid) begin
                  if (ev_cnt < 32'(MAX_EVENTS)) begin
                     chain  <= {chain[250:0], chain[255:251]} ^ {192'b0, ev_data};
                     ev_cnt <= ev_cnt + 32'd1;
                  end else begin
                     overflow <= 1'b1;
                  end
                  if (ev_last) ts_lat <= ts_cnt;
               end
            end
            ST_BUILD: begin
`ifdef XRST_EVIDENCE_CRC_EN
               crc_acc   <= crc_nxt;
               build_cnt <= build_cnt + 4'd1;
               if (build_last) begin
                  build_cnt       <= '0;
                  evidence_packet <= {crc_nxt ^ CRC_XOROUT, {(OFF_CRC-BODY_W){1'b0}}, body};
               end
`else
               evidence_packet <= {{(PKT_W-BODY_W){1'b0}}, body};
`endif
            end
            ST_SEND: begin
               wait_cnt <= '0;
               if (accept) packets_sent <= packets_sent + 32'd1;
            end
            ST_WAIT: begin
               // A done pulse on the timeout cycle counts as success.
               if (!settle_done_in) begin
                  if (settle_to) timeout_count <= timeout_count + 32'd1;
                  else           wait_cnt      <= wait_cnt + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_xrst_evidence_builder.sv
// Scoreboard bench for xrst_evidence_builder: expected packets are queued at stimulus
// time and compared by a monitor when the core accepts a packet.
module tb_xrst_evidence_builder;

   localparam int MAXE = 4;
   localparam int TO   = 16;
`ifdef XRST_EVIDENCE_CRC_EN
   localparam int BUILD_CYC = 11;
`else
   localparam int BUILD_CYC = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          hdr_valid = 1'b0;
   logic [31:0]   hdr_sla_id = '0, hdr_reliability = '0, hdr_penalty = '0, hdr_credit = '0;
   logic [15:0]   hdr_boundary = '0;
   logic [255:0]  hdr_proof = '0;
   logic          ev_valid = 1'b0;
   logic [63:0]   ev_data = '0;
   logic          ev_last = 1'b0;
   logic          ev_ready;
   logic          core_ready_in = 1'b0;
   logic [7:0]    core_state_in = '0;
   logic          settle_done_in = 1'b0;
   logic [4095:0] evidence_packet;
   logic          packet_valid;
   logic          builder_busy;
   logic [2:0]    builder_state;
   logic [31:0]   packets_sent;
   logic [31:0]   timeout_count;
   logic          overflow;

   int checks = 0;
   int failures = 0;
   logic [4095:0] exp_q[$];
   logic [31:0]   tb_ts;

   xrst_evidence_builder #(.MAX_EVENTS(MAXE), .SETTLE_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .hdr_valid(hdr_valid), .hdr_sla_id(hdr_sla_id), .hdr_reliability(hdr_reliability),
      .hdr_penalty(hdr_penalty), .hdr_credit(hdr_credit), .hdr_boundary(hdr_boundary),
      .hdr_proof(hdr_proof),
      .ev_valid(ev_valid), .ev_data(ev_data), .ev_last(ev_last), .ev_ready(ev_ready),
      .core_ready_in(core_ready_in), .core_state_in(core_state_in),
      .settle_done_in(settle_done_in),
      .evidence_packet(evidence_packet), .packet_valid(packet_valid),
      .builder_busy(builder_busy), .builder_state(builder_state),
      .packets_sent(packets_sent), .timeout_count(timeout_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_ts <= '0;
      else        tb_ts <= tb_ts + 32'd1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_model(input logic [703:0] d);
      logic [31:0] c;
      logic fb;
      c = 32'hFFFFFFFF;
      for (int ch = 0; ch < 11; ch++)
         for (int b = 63; b >= 0; b--) begin
            fb = c[31] ^ d[ch*64 + b];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ 32'h04C11DB7;
         end
      return ~c;
   endfunction

   function automatic logic [4095:0] mk_pkt(input logic [31:0] sla, ts, rel, pen, cred,
                                            input logic [15:0] bnd, input logic [255:0] chain,
                                            input logic [255:0] proof, input int cnt);
      logic [4095:0] p;
      p = '0;
      p[31:0]    = sla;
      p[63:32]   = ts;
      p[95:64]   = rel;
      p[127:96]  = pen;
      p[159:128] = cred;
      p[175:160] = bnd;
      p[431:176] = chain;
      p[687:432] = proof;
      p[703:688] = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
`ifdef XRST_EVIDENCE_CRC_EN
      p[4095:4064] = crc_model(p[703:0]);
`endif
      return p;
   endfunction

   // Monitor: compare each accepted packet against the scoreboard head.
   initial begin
      logic [4095:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && packet_valid && core_ready_in && core_state_in == 8'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL pkt_unexpected: got body %h expected none", evidence_packet[703:0]);
            end else begin
               e = exp_q.pop_front();
               if (evidence_packet !== e) begin
                  failures++;
                  $display("FAIL pkt: got crc %h body %h expected crc %h body %h",
                           evidence_packet[4095:4064], evidence_packet[703:0], e[4095:4064], e[703:0]);
               end
            end
         end
      end
   end

   task automatic do_packet(input logic [31:0] sla, rel, pen, cred, input logic [15:0] bnd,
                            input logic [255:0] proof, input int n, input logic [63:0] evs [8],
                            output logic [4095:0] pkt);
      logic [255:0] chain;
      logic [31:0]  ts;
      int cnt, bc;
      chain = '0;
      cnt = 0;
      ts = '0;
      hdr_valid = 1'b1; hdr_sla_id = sla; hdr_reliability = rel; hdr_penalty = pen;
      hdr_credit = cred; hdr_boundary = bnd; hdr_proof = proof;
      tick();
      hdr_valid = 1'b0;
      chk("collect_state", 64'(builder_state), 64'd1);
      chk("collect_ready", 64'(ev_ready), 64'd1);
      for (int i = 0; i < n; i++) begin
         ev_valid = 1'b1;
         ev_data  = evs[i];
         ev_last  = (i == n - 1);
         if (cnt < MAXE) begin
            chain = {chain[250:0], chain[255:251]} ^ {192'b0, evs[i]};
            cnt++;
         end
         if (i == n - 1) ts = tb_ts;
         tick();
      end
      ev_valid = 1'b0;
      ev_last  = 1'b0;
      pkt = mk_pkt(sla, ts, rel, pen, cred, bnd, chain, proof, cnt);
      exp_q.push_back(pkt);
      bc = 0;
      while (builder_state == 3'd2 && bc < 40) begin
         bc++;
         tick();
      end
      chk("build_cycles", 64'(bc), 64'(BUILD_CYC));
      chk("send_state", 64'(builder_state), 64'd3);
      chk("send_valid", 64'(packet_valid), 64'd1);
      chk("send_ev_ready", 64'(ev_ready), 64'd0);
   endtask

   initial begin
      logic [63:0] evs [8];
      logic [4095:0] pkt;
      int bad, wc;

      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 64'(builder_state), 64'd0);
      chk("rst_busy", 64'(builder_busy), 64'd0);
      chk("rst_valid", 64'(packet_valid), 64'd0);
      chk("rst_ev_ready", 64'(ev_ready), 64'd0);
      chk("rst_packet", 64'(|evidence_packet), 64'd0);
      chk("rst_sent", 64'(packets_sent), 64'd0);
      chk("rst_timeouts", 64'(timeout_count), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      chk("idle_ready", 64'(ev_ready), 64'd0);

      // Basic packet, core ready immediately.
      core_ready_in = 1'b1; core_state_in = 8'd0;
      evs[0] = 64'h1; evs[1] = 64'h2;
      do_packet(32'h11, 32'h64, 32'h0, 32'h0, 16'h0A, 256'h0, 2, evs, pkt);
      chk("basic_chain", evidence_packet[239:176], 64'h22);
      chk("basic_count", 64'(evidence_packet[703:688]), 64'd2);
      chk("basic_sla", 64'(evidence_packet[31:0]), 64'h11);
`ifdef XRST_EVIDENCE_CRC_EN
      chk("basic_crc", 64'(evidence_packet[4095:4064]), 64'(crc_model(pkt[703:0])));
`else
      chk("basic_crc_zero", 64'(evidence_packet[4095:4064]), 64'd0);
`endif
      tick();
      chk("basic_wait", 64'(builder_state), 64'd4);
      chk("basic_valid_low", 64'(packet_valid), 64'd0);
      chk("basic_sent", 64'(packets_sent), 64'd1);
      repeat (3) tick();
      settle_done_in = 1'b1;
      tick();
      settle_done_in = 1'b0;
      chk("basic_idle", 64'(builder_state), 64'd0);
      chk("basic_no_timeout", 64'(timeout_count), 64'd0);

      // Handshake stall, then timeout in WAIT.
      core_state_in = 8'd2;
      evs[0] = 64'hAAAA; evs[1] = 64'h5555_0000_0000_0001; evs[2] = 64'hFF;
      do_packet(32'h22, 32'h1234, 32'h10, 32'h20, 16'hBEEF, {8{32'hC0DE_0001}}, 3, evs, pkt);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (!packet_valid || evidence_packet !== pkt) bad++;
         tick();
      end
      chk("stall_hold", 64'(bad), 64'd0);
      chk("stall_sent", 64'(packets_sent), 64'd1);
      core_state_in = 8'd0;
      tick();
      chk("stall_accept_state", 64'(builder_state), 64'd4);
      chk("stall_accept_sent", 64'(packets_sent), 64'd2);
      wc = 0;
      while (builder_state == 3'd4 && wc < 100) begin
         wc++;
         tick();
      end
      chk("timeout_cycles", 64'(wc), 64'd16);
      chk("timeout_count", 64'(timeout_count), 64'd1);
      chk("timeout_idle", 64'(builder_state), 64'd0);

      // Done arriving on the final WAIT cycle wins over the timeout.
      evs[0] = 64'h77;
      do_packet(32'h33, 32'h1, 32'h2, 32'h3, 16'h4, 256'h5, 1, evs, pkt);
      tick();
      repeat (15) tick();
      chk("done16_state", 64'(builder_state), 64'd4);
      settle_done_in = 1'b1;
      tick();
      settle_done_in = 1'b0;
      chk("done16_idle", 64'(builder_state), 64'd0);
      chk("done16_timeouts", 64'(timeout_count), 64'd1);
      chk("done16_sent", 64'(packets_sent), 64'd3);

      // Overflow: 6 events against a limit of 4.
      for (int i = 0; i < 6; i++) evs[i] = 64'h100 << i;
      evs[5] = evs[5] | 64'hF000_0000_0000_0000;
      do_packet(32'h44, 32'h0, 32'h0, 32'h0, 16'h0, 256'h0, 6, evs, pkt);
      chk("ovf_count", 64'(evidence_packet[703:688]), 64'd4);
      chk("ovf_flag", 64'(overflow), 64'd1);
      tick();
      settle_done_in = 1'b1;
      tick();
      settle_done_in = 1'b0;
      chk("ovf_sticky", 64'(overflow), 64'd1);
      chk("ovf_sent", 64'(packets_sent), 64'd4);

      // Reset in the middle of COLLECT.
      hdr_valid = 1'b1; hdr_sla_id = 32'h55;
      tick();
      hdr_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ev_valid = 1'b1; ev_data = 64'hDEAD_0000 + 64'(i);
         tick();
      end
      ev_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_state", 64'(builder_state), 64'd0);
      chk("mrst_busy", 64'(builder_busy), 64'd0);
      chk("mrst_ready", 64'(ev_ready), 64'd0);
      chk("mrst_packet", 64'(|evidence_packet), 64'd0);
      chk("mrst_sent", 64'(packets_sent), 64'd0);
      chk("mrst_timeouts", 64'(timeout_count), 64'd0);
      chk("mrst_overflow", 64'(overflow), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      evs[0] = 64'h5;
      do_packet(32'h66, 32'h7, 32'h8, 32'h9, 16'hA, 256'hB, 1, evs, pkt);
      chk("post_rst_chain", evidence_packet[239:176], 64'h5);
      tick();
      chk("post_rst_sent", 64'(packets_sent), 64'd1);
      settle_done_in = 1'b1;
      tick();
      settle_done_in = 1'b0;
      chk("post_rst_idle", 64'(builder_state), 64'd0);

      repeat (2) tick();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

endmodule
